// File: rtl/multicycle_control_if.sv
// Handshake and strobe bundle between the multicycle control FSM and the datapath.
// mem_ready is sampled only in FETCH, MEM_READ and MEM_WRITE. A memory access completes
// on the first rising clock edge where the request strobe and mem_ready are both 1.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
           illegal_op, mem_timeout, state
  );

  modport slave (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
           illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-32 datapath: sequences fetch/decode/execute/
// memory/write-back, stalls on mem_ready and traps on illegal opcodes or memory timeouts.
module multicycle_control #(
  parameter int unsigned MAX_WAIT = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12,
    S_RESET     = 4'd15
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       cause_q, cause_d;   // 1 = timeout, 0 = illegal opcode
  logic [5:0] op_q, op_d;
  logic       wait_st;
  logic       timeout;

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timeout = wait_st && !bus.mem_ready && (wait_cnt_q == MAX_WAIT_C);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    op_d    = op_q;
    case (state_q)
      S_RESET:     state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default: begin
            state_d = S_TRAP;
            cause_d = 1'b0;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ, S_MEM_WRITE: begin
        if (bus.mem_ready) state_d = (state_q == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_TRAP: state_d = S_FETCH;
      default:     state_d = S_RESET;
    endcase

    // Saturating stall counter; restarts whenever a state is entered or memory answers.
    wait_cnt_d = 8'd0;
    if (wait_st && !bus.mem_ready && (state_d == state_q))
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      wait_cnt_q <= 8'd0;
      cause_q    <= 1'b0;
      op_q       <= 6'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
      op_q       <= op_d;
    end
  end

  // Moore decode; only the FETCH loads are gated by mem_ready.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.mem_timeout = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE:    bus.ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_R_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      S_ADDI_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_ADDI_WB:   bus.RegWrite = 1'b1;
      S_TRAP: begin
        bus.illegal_op  = !cause_q;
        bus.mem_timeout = cause_q;
      end
      default: ;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MAX_WAIT=4): checks state and every strobe per cycle
// against hand-written per-state control words.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEM_ADDR = 4'd2,
                         ST_MEM_READ = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WRITE = 4'd5,
                         ST_EXECUTE = 4'd6, ST_R_WB = 4'd7,   ST_BRANCH = 4'd8,
                         ST_JUMP = 4'd9,    ST_ADDI_EXEC = 4'd10, ST_ADDI_WB = 4'd11,
                         ST_TRAP = 4'd12,   ST_RESET = 4'd15;

  // Control word: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite PCSource[2]
  //               ALUOp[2] ALUSrcA ALUSrcB[2] RegWrite RegDst illegal_op mem_timeout
  localparam logic [17:0] C_ZERO       = 18'b0;
  localparam logic [17:0] C_FETCH_RDY  = {7'b1001001, 2'b00, 2'b00, 1'b0, 2'b01, 4'b0000};
  localparam logic [17:0] C_FETCH_WAIT = {7'b0001000, 2'b00, 2'b00, 1'b0, 2'b01, 4'b0000};
  localparam logic [17:0] C_DECODE     = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 4'b0000};
  localparam logic [17:0] C_MEM_ADDR   = {7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 4'b0000};
  localparam logic [17:0] C_MEM_READ   = {7'b0011000, 2'b00, 2'b00, 1'b0, 2'b00, 4'b0000};
  localparam logic [17:0] C_MEM_WB     = {7'b0000010, 2'b00, 2'b00, 1'b0, 2'b00, 4'b1000};
  localparam logic [17:0] C_MEM_WRITE  = {7'b0010100, 2'b00, 2'b00, 1'b0, 2'b00, 4'b0000};
  localparam logic [17:0] C_EXECUTE    = {7'b0000000, 2'b00, 2'b10, 1'b1, 2'b00, 4'b0000};
  localparam logic [17:0] C_R_WB       = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 4'b1100};
  localparam logic [17:0] C_BRANCH     = {7'b0100000, 2'b01, 2'b01, 1'b1, 2'b00, 4'b0000};
  localparam logic [17:0] C_JUMP       = {7'b1000000, 2'b10, 2'b00, 1'b0, 2'b00, 4'b0000};
  localparam logic [17:0] C_ADDI_EXEC  = {7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 4'b0000};
  localparam logic [17:0] C_ADDI_WB    = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 4'b1000};
  localparam logic [17:0] C_TRAP_ILL   = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 4'b0010};
  localparam logic [17:0] C_TRAP_TO    = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 4'b0001};

  logic [17:0] ctl_obs;
  assign ctl_obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.MemtoReg, bus.IRWrite, bus.PCSource, bus.ALUOp, bus.ALUSrcA,
                    bus.ALUSrcB, bus.RegWrite, bus.RegDst, bus.illegal_op, bus.mem_timeout};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1: drive mem_ready, check this cycle, advance to the next posedge+1.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] ctl,
                     input logic rdy);
    bus.mem_ready = rdy;
    #1;
    check({tag, "_state"}, 32'(bus.state), 32'(st));
    check({tag, "_ctl"}, 32'(ctl_obs), 32'(ctl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_low_state", 32'(bus.state), 32'(ST_RESET));
    check("rst_low_ctl", 32'(ctl_obs), 32'(C_ZERO));
    rst_n = 1'b1;
    cyc("rst_rel", ST_RESET, C_ZERO, 1'b1);

    // R-type, zero wait
    bus.opcode = 6'b000000;
    cyc("r_fetch", ST_FETCH, C_FETCH_RDY, 1'b1);
    cyc("r_decode", ST_DECODE, C_DECODE, 1'b1);
    cyc("r_exec", ST_EXECUTE, C_EXECUTE, 1'b1);
    cyc("r_wb", ST_R_WB, C_R_WB, 1'b1);

    // lw with 3 waits; opcode flips to sw after DECODE and mem_ready low outside memory states
    bus.opcode = 6'b100011;
    cyc("lw_fetch", ST_FETCH, C_FETCH_RDY, 1'b1);
    cyc("lw_decode", ST_DECODE, C_DECODE, 1'b0);
    bus.opcode = 6'b101011;
    cyc("lw_addr", ST_MEM_ADDR, C_MEM_ADDR, 1'b0);
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", ST_MEM_READ, C_MEM_READ, 1'b0);
    cyc("lw_rd_done", ST_MEM_READ, C_MEM_READ, 1'b1);
    cyc("lw_wb", ST_MEM_WB, C_MEM_WB, 1'b1);

    // beq, j, illegal, addi
    bus.opcode = 6'b000100;
    cyc("beq_fetch", ST_FETCH, C_FETCH_RDY, 1'b1);
    cyc("beq_decode", ST_DECODE, C_DECODE, 1'b1);
    cyc("beq_branch", ST_BRANCH, C_BRANCH, 1'b1);
    bus.opcode = 6'b000010;
    cyc("j_fetch", ST_FETCH, C_FETCH_RDY, 1'b1);
    cyc("j_decode", ST_DECODE, C_DECODE, 1'b1);
    cyc("j_jump", ST_JUMP, C_JUMP, 1'b1);
    bus.opcode = 6'b111111;
    cyc("ill_fetch", ST_FETCH, C_FETCH_RDY, 1'b1);
    cyc("ill_decode", ST_DECODE, C_DECODE, 1'b1);
    bus.opcode = 6'b000000;
    cyc("ill_trap", ST_TRAP, C_TRAP_ILL, 1'b1);
    bus.opcode = 6'b001000;
    cyc("addi_fetch", ST_FETCH, C_FETCH_RDY, 1'b1);
    cyc("addi_decode", ST_DECODE, C_DECODE, 1'b1);
    cyc("addi_exec", ST_ADDI_EXEC, C_ADDI_EXEC, 1'b1);
    cyc("addi_wb", ST_ADDI_WB, C_ADDI_WB, 1'b1);

    // sw with memory stuck: MAX_WAIT+1 = 5 cycles in MEM_WRITE, then timeout trap
    bus.opcode = 6'b101011;
    cyc("swto_fetch", ST_FETCH, C_FETCH_RDY, 1'b1);
    cyc("swto_decode", ST_DECODE, C_DECODE, 1'b1);
    cyc("swto_addr", ST_MEM_ADDR, C_MEM_ADDR, 1'b1);
    for (int i = 0; i < 5; i++) cyc("swto_wait", ST_MEM_WRITE, C_MEM_WRITE, 1'b0);
    cyc("swto_trap", ST_TRAP, C_TRAP_TO, 1'b0);

    // FETCH stall of 3, then sw completing on the 5th MEM_WRITE cycle (no trap)
    for (int i = 0; i < 3; i++) cyc("sw_fetch_wait", ST_FETCH, C_FETCH_WAIT, 1'b0);
    cyc("sw_fetch", ST_FETCH, C_FETCH_RDY, 1'b1);
    cyc("sw_decode", ST_DECODE, C_DECODE, 1'b1);
    cyc("sw_addr", ST_MEM_ADDR, C_MEM_ADDR, 1'b1);
    for (int i = 0; i < 4; i++) cyc("sw_wait", ST_MEM_WRITE, C_MEM_WRITE, 1'b0);
    cyc("sw_done", ST_MEM_WRITE, C_MEM_WRITE, 1'b1);

    // Reset mid-instruction during a stalled lw read
    bus.opcode = 6'b100011;
    cyc("mrst_fetch", ST_FETCH, C_FETCH_RDY, 1'b1);
    cyc("mrst_decode", ST_DECODE, C_DECODE, 1'b1);
    cyc("mrst_addr", ST_MEM_ADDR, C_MEM_ADDR, 1'b1);
    cyc("mrst_rd", ST_MEM_READ, C_MEM_READ, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_async_state", 32'(bus.state), 32'(ST_RESET));
    check("mrst_async_ctl", 32'(ctl_obs), 32'(C_ZERO));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("mrst_rel", ST_RESET, C_ZERO, 1'b1);
    cyc("mrst_refetch", ST_FETCH, C_FETCH_RDY, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
